// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator: operation encoding and its width.
package accum_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple-carry adder/subtractor: sum = a + (sub ? ~b + 1 : b).
module addsub_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             v
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_c;

    always_comb begin
        w_b_eff = b ^ {WIDTH{sub}};
        w_c     = '0;
        sum     = '0;
        w_c[0]  = sub;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i]   = a[i] ^ w_b_eff[i] ^ w_c[i];
            w_c[i+1] = (a[i] & w_b_eff[i]) | (w_c[i] & (a[i] ^ w_b_eff[i]));
        end
    end

    assign carry = w_c[WIDTH];
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign v     = w_c[WIDTH] ^ w_c[WIDTH-1];

endmodule

// File: rtl/accum_addsub.sv
// Two-stage accumulator: stage 1 registers the request, stage 2 updates acc and flags,
// with optional signed saturation and a sticky overflow flag.
module accum_addsub
    import accum_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic             sticky_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] acc,
    output logic             carry_out,
    output logic             ovr,
    output logic             ovr_sticky
);

    localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_a;
    op_e              r_op;
    logic             r_v;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_ovr;
    logic             r_sticky;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_v;
    logic             w_sub;
    logic             w_arith;
    logic             w_b_msb;
    logic [WIDTH-1:0] w_sat;
    logic [WIDTH-1:0] w_acc_d;
    logic             w_carry_d;
    logic             w_ovr_d;
    logic             w_sticky_d;

    assign w_sub   = (r_op == OP_SUB);
    assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

    addsub_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a    (r_acc),
        .b    (r_a),
        .sub  (w_sub),
        .sum  (w_sum),
        .carry(w_cout),
        .v    (w_v)
    );

    // Overflow only happens with equal operand signs, so the accumulator sign picks the rail.
    assign w_b_msb = r_a[WIDTH-1] ^ w_sub;
    assign w_sat   = (!r_acc[WIDTH-1] && !w_b_msb) ? SatMax : SatMin;

    always_comb begin
        w_acc_d   = r_acc;
        w_carry_d = r_carry;
        w_ovr_d   = r_ovr;
        if (r_v) begin
            unique case (r_op)
                OP_ADD, OP_SUB: begin
                    w_acc_d   = (SATURATE && w_v) ? w_sat : w_sum;
                    w_carry_d = w_cout;
                    w_ovr_d   = w_v;
                end
                OP_LOAD: begin
                    w_acc_d   = r_a;
                    w_carry_d = 1'b0;
                    w_ovr_d   = 1'b0;
                end
                OP_CLR: begin
                    w_acc_d   = '0;
                    w_carry_d = 1'b0;
                    w_ovr_d   = 1'b0;
                end
            endcase
        end
        // Set wins over clear.
        w_sticky_d = (r_v && w_arith && w_v) || (r_sticky && !sticky_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a         <= '0;
            r_op        <= OP_ADD;
            r_v         <= 1'b0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_ovr       <= 1'b0;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_a         <= a;
            r_op        <= op_e'(op);
            r_v         <= in_valid;
            r_acc       <= w_acc_d;
            r_carry     <= w_carry_d;
            r_ovr       <= w_ovr_d;
            r_sticky    <= w_sticky_d;
            r_out_valid <= r_v;
        end
    end

    assign out_valid  = r_out_valid;
    assign acc        = r_acc;
    assign carry_out  = r_carry;
    assign ovr        = r_ovr;
    assign ovr_sticky = r_sticky;

endmodule

// File: tb/tb_accum_addsub.sv
// Directed bench: one wrapping and one saturating instance share stimulus.
module tb_accum_addsub;
    import accum_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] op = 2'd0;
    logic [7:0] a = 8'h00;
    logic       sticky_clr = 1'b0;

    logic       ov0, ov1, cy0, cy1, ovr0, ovr1, st0, st1;
    logic [7:0] acc0, acc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accum_addsub #(.WIDTH(8), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .a(a),
        .sticky_clr(sticky_clr), .out_valid(ov0), .acc(acc0),
        .carry_out(cy0), .ovr(ovr0), .ovr_sticky(st0)
    );

    accum_addsub #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .a(a),
        .sticky_clr(sticky_clr), .out_valid(ov1), .acc(acc1),
        .carry_out(cy1), .ovr(ovr1), .ovr_sticky(st1)
    );

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input op_e o, input logic [7:0] val);
        in_valid = 1'b1;
        op       = o;
        a        = val;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        check8("rst_acc", acc0, 8'h00);
        check1("rst_ov", ov0, 1'b0);
        check1("rst_sticky", st1, 1'b0);
        rst = 1'b1;

        // LOAD FF, ADD 01 -> 00 with carry; latency check on the LOAD
        issue(OP_LOAD, 8'hFF);
        check1("lat_ov_early", ov0, 1'b0);
        issue(OP_ADD, 8'h01);
        check1("lat_ov", ov0, 1'b1);
        check8("lat_acc", acc0, 8'hFF);
        idle();
        check8("wrapff_acc", acc0, 8'h00);
        check1("wrapff_cy", cy0, 1'b1);
        check1("wrapff_ovr", ovr0, 1'b0);
        check1("wrapff_sticky", st0, 1'b0);

        // LOAD 01, ADD 7F -> signed overflow
        issue(OP_LOAD, 8'h01);
        issue(OP_ADD, 8'h7F);
        idle();
        check8("ovadd_acc_wrap", acc0, 8'h80);
        check1("ovadd_ovr_wrap", ovr0, 1'b1);
        check1("ovadd_cy_wrap", cy0, 1'b0);
        check8("ovadd_acc_sat", acc1, 8'h7F);
        check1("ovadd_ovr_sat", ovr1, 1'b1);
        check1("ovadd_st_wrap", st0, 1'b1);
        check1("ovadd_st_sat", st1, 1'b1);
        sticky_clr = 1'b1;
        idle();
        sticky_clr = 1'b0;
        check1("stclr_st", st0, 1'b0);
        check1("stclr_ovr_held", ovr0, 1'b1);

        // CLR, SUB 01 -> FF with borrow
        issue(OP_CLR, 8'h00);
        issue(OP_SUB, 8'h01);
        idle();
        check8("sub_acc_wrap", acc0, 8'hFF);
        check8("sub_acc_sat", acc1, 8'hFF);
        check1("sub_cy", cy0, 1'b0);
        check1("sub_ovr", ovr0, 1'b0);
        check1("sub_st", st0, 1'b0);

        // LOAD 80, SUB 01 -> negative overflow
        issue(OP_LOAD, 8'h80);
        issue(OP_SUB, 8'h01);
        idle();
        check8("negov_acc_sat", acc1, 8'h80);
        check1("negov_ovr_sat", ovr1, 1'b1);
        check8("negov_acc_wrap", acc0, 8'h7F);
        check1("negov_cy_wrap", cy0, 1'b1);

        // Sticky: overflow and clear on the same edge, then clear alone
        sticky_clr = 1'b1;
        idle();
        sticky_clr = 1'b0;
        check1("st_pre", st0, 1'b0);
        issue(OP_LOAD, 8'h01);
        issue(OP_ADD, 8'h7F);
        sticky_clr = 1'b1;
        idle();
        check1("st_setwins", st0, 1'b1);
        check1("st_setwins_ovr", ovr0, 1'b1);
        idle();
        sticky_clr = 1'b0;
        check1("st_cleared", st0, 1'b0);

        // Throughput: CLR then three back-to-back ADD 01
        issue(OP_CLR, 8'h00);
        issue(OP_ADD, 8'h01);
        check1("tp_ov0", ov0, 1'b1);
        check8("tp_acc0", acc0, 8'h00);
        issue(OP_ADD, 8'h01);
        check1("tp_ov1", ov0, 1'b1);
        check8("tp_acc1", acc0, 8'h01);
        issue(OP_ADD, 8'h01);
        check1("tp_ov2", ov0, 1'b1);
        check8("tp_acc2", acc0, 8'h02);
        idle();
        check1("tp_ov3", ov0, 1'b1);
        check8("tp_acc3", acc0, 8'h03);
        idle();
        check1("tp_ov_end", ov0, 1'b0);
        check8("tp_hold1", acc0, 8'h03);
        idle();
        check8("tp_hold2", acc0, 8'h03);
        check1("tp_ov_idle", ov0, 1'b0);

        // Asynchronous reset mid-stream with a LOAD in stage 1
        issue(OP_LOAD, 8'h55);
        rst = 1'b0;
        #1;
        check8("arst_acc", acc0, 8'h00);
        check1("arst_cy", cy0, 1'b0);
        check1("arst_ovr", ovr1, 1'b0);
        check1("arst_ov", ov0, 1'b0);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        idle();
        check1("post_rst_ov1", ov0, 1'b0);
        check8("post_rst_acc1", acc0, 8'h00);
        idle();
        check1("post_rst_ov2", ov0, 1'b0);
        check8("post_rst_acc2", acc0, 8'h00);
        issue(OP_LOAD, 8'h12);
        idle();
        check1("post_rst_load_ov", ov0, 1'b1);
        check8("post_rst_load_acc", acc0, 8'h12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_addsub.md
ACCUM_ADDSUB -- requirements
Module: accum_addsub

Interface
REQ-001 Parameter WIDTH, default 8, accumulator and operand width in bits (legal range 2..32).
REQ-002 Parameter SATURATE, default 0, 1 = clamp signed result on overflow, 0 = wrap.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand/op qualifier, sampled each rising edge.
REQ-006 op  input  2  operation: 0 ADD, 1 SUB, 2 LOAD, 3 CLR.
REQ-007 a  input  WIDTH  operand, two's complement or unsigned (flags cover both).
REQ-008 sticky_clr  input  1  synchronous clear of ovr_sticky.
REQ-009 out_valid  output  1  one-cycle pulse per completed operation.
REQ-010 acc  output  WIDTH  accumulator register.
REQ-011 carry_out  output  1  unsigned carry (ADD) / no-borrow (SUB) of the last operation.
REQ-012 ovr  output  1  signed overflow of the last operation.
REQ-013 ovr_sticky  output  1  set by any ovr, held until sticky_clr.

Function
REQ-014 Stage 1 SHALL register a, op and in_valid every cycle unconditionally (a_q, op_q, v_q).
REQ-015 Stage 2 SHALL update acc, carry_out, ovr only when v_q=1; otherwise hold them.
REQ-016 Latency: operation presented at edge N SHALL appear on acc/flags after edge N+1, with out_valid=1 in that same cycle; out_valid SHALL equal v_q delayed one edge.
REQ-017 Throughput: one operation per cycle; back-to-back operations SHALL chain, each using the acc produced by the previous one.
REQ-018 ADD: result = acc + a_q; carry_out = bit WIDTH of the WIDTH+1-bit sum; ovr = carry into MSB XOR carry out of MSB.
REQ-019 SUB: result = acc + ~a_q + 1; carry_out = 1 when acc >= a_q unsigned (no borrow); ovr per REQ-018 on the same adder.
REQ-020 LOAD: acc <= a_q; carry_out <= 0; ovr <= 0.
REQ-021 CLR: acc <= 0; carry_out <= 0; ovr <= 0; ovr_sticky unaffected.
REQ-022 SATURATE=0: acc takes result[WIDTH-1:0] (wrap-around).
REQ-023 SATURATE=1 and ovr=1: acc SHALL take 2^(WIDTH-1)-1 if both operands (after SUB inversion) are non-negative, else -2^(WIDTH-1); ovr and carry_out still report the raw result.
REQ-024 ovr_sticky SHALL set on any edge where stage 2 produces ovr=1; sticky_clr clears it; simultaneous set and clear SHALL leave it set.
REQ-025 Unused op encodings do not exist; all four values SHALL be decoded.

Reset
REQ-026 rst low SHALL asynchronously force a_q=0, op_q=0, v_q=0, acc=0, carry_out=0, ovr=0, ovr_sticky=0, out_valid=0.
REQ-027 Operations in stage 1 when reset asserts SHALL be discarded; first operation after release takes effect per REQ-016.
REQ-028 Reset release is synchronous to clk by the integrator; block SHALL not self-synchronise.

Structure
REQ-029 Shared package accum_pkg SHALL hold the op enum typedef (OP_ADD, OP_SUB, OP_LOAD, OP_CLR) and its width constant.
REQ-030 One combinational sub-module addsub_core (parametrised WIDTH: a, b, sub in; sum, carry, v out) SHALL implement the ripple add/sub; the top holds all registers and saturation.

Verification (WIDTH=8)
REQ-031 Reset: rst low mid-stream with in_valid=1 -> all outputs 0 immediately without a clock edge; no out_valid after release until new input.
REQ-032 LOAD 0x01 then ADD 0x7F -> SATURATE=0: acc=0x80, ovr=1, carry_out=0; SATURATE=1: acc=0x7F, ovr=1; ovr_sticky=1 both.
REQ-033 CLR then SUB 0x01 -> acc=0xFF, carry_out=0, ovr=0; LOAD 0x80 then SUB 0x01, SATURATE=1 -> acc=0x80, ovr=1.
REQ-034 LOAD 0xFF then ADD 0x01 -> acc=0x00, carry_out=1, ovr=0.
REQ-035 Sticky: overflowing ADD in stage 2 with sticky_clr=1 same cycle -> ovr_sticky=1; next cycle sticky_clr=1, no overflow -> 0.
REQ-036 Throughput: CLR, then ADD 0x01 on 3 consecutive cycles -> acc 0x01, 0x02, 0x03 on consecutive cycles, out_valid high 4 cycles contiguous, then 0; idle gap holds acc=0x03.
